adr_seq_ctrl: RTL and testbench

- Controller that sequences the address register datapath.
- Drives the 3-bit state code st through 0..LAST_ST in ascending order. Each code is held for a programmable number of clock cycles.
- start/busy/done handshake toward the host controller; abort terminates a run.
- Sits between the host controller and the address register datapath, whose st input it drives directly.

---
 rtl/adr_seq_pkg.sv | 20 ++
 rtl/adr_hold_timer.sv | 33 +++
 rtl/adr_seq_ctrl.sv | 151 +++++++++++++++
 tb/tb_adr_seq_ctrl.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/adr_seq_pkg.sv
`default_nettype none
// ============================================================================
// Module      : adr_seq_pkg
// Description : Shared types and default sizing for the address sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
package adr_seq_pkg;

    localparam int ST_W_DEF    = 3;
    localparam int LAST_ST_DEF = 7;
    localparam int HOLD_W_DEF  = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } seq_state_t;

endpackage : adr_seq_pkg
`default_nettype wire

// File: rtl/adr_hold_timer.sv
`default_nettype none
// ============================================================================
// Module      : adr_hold_timer
// Description : Loadable down-counter; expire is high while enabled at zero.
// Revision    : 1.0 - initial release
// ============================================================================
module adr_hold_timer #(
    parameter int HOLD_W = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load,
    input  logic [HOLD_W-1:0] load_val,
    input  logic              en,
    output logic              expire
);

    logic [HOLD_W-1:0] r_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (load) begin
            r_cnt <= load_val;
        end else if (en && (r_cnt != '0)) begin
            r_cnt <= r_cnt - HOLD_W'(1);
        end
    end

    assign expire = en && (r_cnt == '0);

endmodule : adr_hold_timer
`default_nettype wire

// File: rtl/adr_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : adr_seq_ctrl
// Description : Steps st through 0..LAST_ST, holding each code H cycles, with
//               start/busy/done handshake and abort. ADR_SEQ_LOOP_EN adds
//               continuous looping (loop input, wrap pulse).
// Revision    : 1.0 - initial release
// ============================================================================
module adr_seq_ctrl
    import adr_seq_pkg::*;
#(
    parameter int ST_W    = ST_W_DEF,
    parameter int LAST_ST = LAST_ST_DEF,
    parameter int HOLD_W  = HOLD_W_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              abort,
    input  logic [HOLD_W-1:0] hold_cyc,
`ifdef ADR_SEQ_LOOP_EN
    input  logic              loop,
    output logic              wrap,
`endif
    output logic [ST_W-1:0]   st,
    output logic              st_valid,
    output logic              busy,
    output logic              done
);

    seq_state_t        r_state, w_state_nxt;
    logic [ST_W-1:0]   r_st, w_st_nxt;
    logic              r_st_valid, w_st_valid_nxt;
    logic              r_busy, w_busy_nxt;
    logic              r_done, w_done_nxt;
    logic              r_wrap, w_wrap_nxt;
    logic              r_loop;
    logic [HOLD_W-1:0] r_hold_m1;
    logic [HOLD_W-1:0] w_hold_in_m1;
    logic [HOLD_W-1:0] w_load_val;
    logic              w_accept;
    logic              w_expire;
    logic              w_load;

    // Timer holds H-1 so that a zero request still yields one-cycle steps
    assign w_hold_in_m1 = (hold_cyc == '0) ? '0 : (hold_cyc - HOLD_W'(1));
    assign w_accept     = (r_state == IDLE) && start;
    assign w_load       = w_accept || ((r_state == RUN) && w_expire && !abort);
    assign w_load_val   = w_accept ? w_hold_in_m1 : r_hold_m1;

    adr_hold_timer #(
        .HOLD_W (HOLD_W)
    ) u_hold_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (w_load),
        .load_val (w_load_val),
        .en       (r_state == RUN),
        .expire   (w_expire)
    );

    always_comb begin
        w_state_nxt    = r_state;
        w_st_nxt       = r_st;
        w_st_valid_nxt = 1'b0;
        w_busy_nxt     = 1'b0;
        w_done_nxt     = 1'b0;
        w_wrap_nxt     = 1'b0;
        unique case (r_state)
            IDLE: begin
                w_st_nxt = '0;
                if (start) begin
                    w_state_nxt    = RUN;
                    w_st_valid_nxt = 1'b1;
                    w_busy_nxt     = 1'b1;
                end
            end
            RUN: begin
                w_st_valid_nxt = 1'b1;
                w_busy_nxt     = 1'b1;
                // abort outranks both step advance and completion
                if (abort) begin
                    w_state_nxt    = IDLE;
                    w_st_nxt       = '0;
                    w_st_valid_nxt = 1'b0;
                    w_busy_nxt     = 1'b0;
                end else if (w_expire) begin
                    if (r_st == ST_W'(LAST_ST)) begin
                        w_st_nxt = '0;
                        if (r_loop) begin
                            w_wrap_nxt = 1'b1;
                        end else begin
                            w_state_nxt    = DONE;
                            w_st_valid_nxt = 1'b0;
                            w_busy_nxt     = 1'b0;
                            w_done_nxt     = 1'b1;
                        end
                    end else begin
                        w_st_nxt = r_st + ST_W'(1);
                    end
                end
            end
            DONE: begin
                w_state_nxt = IDLE;
                w_st_nxt    = '0;
            end
            default: begin
                w_state_nxt = IDLE;
                w_st_nxt    = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= IDLE;
            r_st       <= '0;
            r_st_valid <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_wrap     <= 1'b0;
            r_loop     <= 1'b0;
            r_hold_m1  <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_st       <= w_st_nxt;
            r_st_valid <= w_st_valid_nxt;
            r_busy     <= w_busy_nxt;
            r_done     <= w_done_nxt;
            r_wrap     <= w_wrap_nxt;
            if (w_accept) begin
                r_hold_m1 <= w_hold_in_m1;
`ifdef ADR_SEQ_LOOP_EN
                r_loop    <= loop;
`else
                r_loop    <= 1'b0;
`endif
            end
        end
    end

    assign st       = r_st;
    assign st_valid = r_st_valid;
    assign busy     = r_busy;
    assign done     = r_done;
`ifdef ADR_SEQ_LOOP_EN
    assign wrap     = r_wrap;
`endif

endmodule : adr_seq_ctrl
`default_nettype wire

// File: tb/tb_adr_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_adr_seq_ctrl
// Description : Directed self-checking bench for adr_seq_ctrl (8 codes/pass).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_adr_seq_ctrl;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic       abort;
    logic [3:0] hold_cyc;
    logic [2:0] st;
    logic       st_valid;
    logic       busy;
    logic       done;
`ifdef ADR_SEQ_LOOP_EN
    logic       loop;
    logic       wrap;
`endif

    int n_chk;
    int n_err;

    adr_seq_ctrl u_dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .abort    (abort),
        .hold_cyc (hold_cyc),
`ifdef ADR_SEQ_LOOP_EN
        .loop     (loop),
        .wrap     (wrap),
`endif
        .st       (st),
        .st_valid (st_valid),
        .busy     (busy),
        .done     (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input int got, input int exp);
        n_chk++;
        if (got != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic check_outs(input string tag, input int e_st, input int e_vld,
                              input int e_busy, input int e_done);
        chk({tag, ".st"},       int'(st),       e_st);
        chk({tag, ".st_valid"}, int'(st_valid), e_vld);
        chk({tag, ".busy"},     int'(busy),     e_busy);
        chk({tag, ".done"},     int'(done),     e_done);
    endtask

    // Advance one edge; sample and drive 1 time unit after it
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One pass with optional abort, stray start, or mid-run hold_cyc change
    task automatic run_pass(input string name, input int hold_in, input int h,
                            input int abort_k, input int abort_j,
                            input int xstart_k, input bit start_in_done,
                            input bit hold_change);
        bit aborted;
        aborted  = 1'b0;
        hold_cyc = 4'(hold_in);
        start    = 1'b1;
        step();
        start    = 1'b0;
        for (int k = 0; k < 8; k++) begin
            for (int j = 0; j < h; j++) begin
                if (!aborted) begin
                    check_outs($sformatf("%s.k%0d.j%0d", name, k, j), k, 1, 1, 0);
                    if (hold_change && k == 2 && j == 0) hold_cyc = 4'd9;
                    if (k == xstart_k && j == 0) start = 1'b1;
                    if (k == abort_k && j == abort_j) begin
                        abort   = 1'b1;
                        aborted = 1'b1;
                    end
                    step();
                    start = 1'b0;
                    abort = 1'b0;
                end
            end
        end
        if (aborted) begin
            check_outs({name, ".aborted"}, 0, 0, 0, 0);
            for (int i = 0; i < 30; i++) begin
                chk({name, ".no_done"}, int'(done), 0);
                step();
            end
        end else begin
            check_outs({name, ".done"}, 0, 0, 0, 1);
            if (start_in_done) start = 1'b1;
            step();
            start = 1'b0;
            check_outs({name, ".idle"}, 0, 0, 0, 0);
            step();
            check_outs({name, ".idle2"}, 0, 0, 0, 0);
        end
    endtask

    initial begin
        n_chk    = 0;
        n_err    = 0;
        rst_n    = 1'b0;
        start    = 1'b0;
        abort    = 1'b0;
        hold_cyc = 4'd1;
`ifdef ADR_SEQ_LOOP_EN
        loop     = 1'b0;
`endif
        step();
        step();
        check_outs("reset", 0, 0, 0, 0);
        rst_n = 1'b1;
        step();
        check_outs("post_reset_idle", 0, 0, 0, 0);

        // Reset mid-run at st=3: outputs clear immediately, no done later
        hold_cyc = 4'd1;
        start    = 1'b1;
        step();
        start    = 1'b0;
        step();
        step();
        step();
        check_outs("pre_rst.st3", 3, 1, 1, 0);
        #2 rst_n = 1'b0;
        #1 check_outs("mid_rst", 0, 0, 0, 0);
        step();
        rst_n = 1'b1;
        for (int i = 0; i < 12; i++) begin
            check_outs("after_rst", 0, 0, 0, 0);
            step();
        end

        run_pass("h1",     1, 1, -1, 0, -1, 1'b0, 1'b0);
        run_pass("h2",     2, 2, -1, 0, -1, 1'b0, 1'b0);
        run_pass("h0",     0, 1, -1, 0, -1, 1'b0, 1'b0);
        run_pass("ab_last", 3, 3, 7, 2, -1, 1'b0, 1'b0);
        run_pass("ab_st2", 1, 1, 2, 0, -1, 1'b0, 1'b0);
        run_pass("xstart", 1, 1, -1, 0, 4, 1'b1, 1'b0);
        run_pass("hchg",   2, 2, -1, 0, -1, 1'b0, 1'b1);

        // start and abort together in IDLE: start wins
        hold_cyc = 4'd1;
        start    = 1'b1;
        abort    = 1'b1;
        step();
        start    = 1'b0;
        abort    = 1'b0;
        check_outs("start_abort_idle", 0, 1, 1, 0);
        abort = 1'b1;
        step();
        abort = 1'b0;
        check_outs("start_abort_cleanup", 0, 0, 0, 0);

`ifdef ADR_SEQ_LOOP_EN
        loop     = 1'b1;
        hold_cyc = 4'd1;
        start    = 1'b1;
        step();
        start    = 1'b0;
        loop     = 1'b0;
        for (int i = 0; i < 20; i++) begin
            chk($sformatf("loop.st.%0d", i),   int'(st),   i % 8);
            chk($sformatf("loop.wrap.%0d", i), int'(wrap), (i > 0 && i % 8 == 0) ? 1 : 0);
            chk($sformatf("loop.done.%0d", i), int'(done), 0);
            chk($sformatf("loop.busy.%0d", i), int'(busy), 1);
            step();
        end
        abort = 1'b1;
        step();
        abort = 1'b0;
        check_outs("loop.abort", 0, 0, 0, 0);
        chk("loop.abort.wrap", int'(wrap), 0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule : tb_adr_seq_ctrl
`default_nettype wire
